// File: rtl/onewire_host.sv
// -----------------------------------------------------------------------------
// onewire_host -- 1-Wire bus master, one reset/presence or bit slot per command.
//
// Purpose:
//   Generates 1-Wire reset/presence cycles and read/write bit slots from
//   a simple valid/ready command interface. It returns one response strobe per
//   completed cycle. Slot timing is counter-driven only. A wire that a
//   slave holds low can delay the sampled value, but it never stalls the
//   state machine.
//
// Parameters:
//   TSC      clock cycles per normal-speed time slot (multiple of 32).
//            The quarter-slot tick is TSC/4 clocks in normal mode and
//            TSC/32 clocks in overdrive mode.
//
// Configuration macro:
//   ONEWIRE_HOST_OVD_EN  defined   -> cmd_ovd selects overdrive timing.
//                        undefined -> cmd_ovd is ignored and every cycle
//                                     uses normal timing.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   cmd_vld  in   command valid
//   cmd_rdy  out  command ready (high only while idle)
//   cmd_rst  in   1 = reset/presence cycle, 0 = bit slot
//   cmd_dat  in   bit to write (1 also serves as a read slot)
//   cmd_ovd  in   overdrive select for this cycle
//   rsp_vld  out  one-clock response strobe
//   rsp_dat  out  sampled bit (bit slot) or presence detected (reset cycle)
//   owr_oe   out  1 = pull the wire low (open-drain enable)
//   owr_i    in   wire level, asynchronous to clk
// -----------------------------------------------------------------------------
module onewire_host #(
  parameter int TSC = 320
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_vld,
  output logic cmd_rdy,
  input  logic cmd_rst,
  input  logic cmd_dat,
  input  logic cmd_ovd,
  output logic rsp_vld,
  output logic rsp_dat,
  output logic owr_oe,
  input  logic owr_i
);

  localparam int QN = TSC / 4;   // normal quarter-slot length in clocks
  localparam int QO = TSC / 32;  // overdrive quarter-slot length in clocks
  localparam int PW = (QN > 1) ? $clog2(QN) : 1;

  localparam logic [PW-1:0] QN_LAST = PW'(QN - 1);
  localparam logic [PW-1:0] QO_LAST = PW'(QO - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIT  = 2'd1,
    RST  = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    sync;      // two-flop synchronizer for owr_i
  logic [PW-1:0] pre;       // prescaler within one quarter slot
  logic [5:0]    qtr;       // quarter-slot index within the cycle
  logic          ovd;       // overdrive timing latched at acceptance
  logic          wr1;       // cmd_dat latched at acceptance
  logic          smp;       // wire level captured at the sample point

  logic          ovd_sel;
  logic          owr_s;
  logic          q_end;
  logic [5:0]    oe_qtr;
  logic [5:0]    smp_qtr;
  logic [5:0]    last_qtr;

`ifdef ONEWIRE_HOST_OVD_EN
  assign ovd_sel = cmd_ovd;
`else
  // Without overdrive support the select is forced off. The port stays
  // in the list, so the interface is the same in both builds.
  assign ovd_sel = cmd_ovd & 1'b0;
`endif

  assign owr_s = sync[1];
  assign q_end = (pre == (ovd ? QO_LAST : QN_LAST));

  // Quarter at whose end each event happens. The values depend on the cycle type.
  always_comb begin
    oe_qtr   = wr1 ? 6'd0 : 6'd5;
    smp_qtr  = 6'd1;
    last_qtr = 6'd7;
    if (state == RST) begin
      oe_qtr   = 6'd39;
      smp_qtr  = 6'd49;
      last_qtr = 6'd63;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], owr_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pre     <= '0;
      qtr     <= '0;
      ovd     <= 1'b0;
      wr1     <= 1'b0;
      smp     <= 1'b0;
      cmd_rdy <= 1'b0;
      rsp_vld <= 1'b0;
      rsp_dat <= 1'b0;
      owr_oe  <= 1'b0;
    end else begin
      rsp_vld <= 1'b0;
      case (state)
        IDLE: begin
          owr_oe <= 1'b0;
          if (cmd_vld && cmd_rdy) begin
            state   <= cmd_rst ? RST : BIT;
            wr1     <= cmd_dat;
            ovd     <= ovd_sel;
            pre     <= '0;
            qtr     <= '0;
            owr_oe  <= 1'b1;
            cmd_rdy <= 1'b0;
          end else begin
            // When a cycle has just ended, cmd_rdy rises one clock after rsp_vld.
            cmd_rdy <= 1'b1;
          end
        end

        BIT, RST: begin
          if (q_end) begin
            pre <= '0;
            qtr <= qtr + 6'd1;
            if (qtr == oe_qtr) begin
              owr_oe <= 1'b0;
            end
            if (qtr == smp_qtr) begin
              smp <= owr_s;
            end
            if (qtr == last_qtr) begin
              state   <= IDLE;
              owr_oe  <= 1'b0;
              rsp_vld <= 1'b1;
              // A slave that holds the wire low during a reset cycle signals presence.
              rsp_dat <= (state == RST) ? ~smp : smp;
            end
          end else begin
            pre <= pre + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          owr_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_host.sv
// -----------------------------------------------------------------------------
// tb_onewire_host -- scoreboard testbench for onewire_host (TSC = 320).
//
// The driver issues each command and pushes the expected response onto a
// queue. The expected response holds the bit, the absolute response clock and
// the number of clocks owr_oe was high. A separate monitor pops one entry per
// rsp_vld strobe and compares. A behavioural slave pulls the wire low in set
// windows relative to the acceptance clock.
// -----------------------------------------------------------------------------
module tb_onewire_host;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_vld = 1'b0;
  logic cmd_rdy;
  logic cmd_rst = 1'b0;
  logic cmd_dat = 1'b0;
  logic cmd_ovd = 1'b0;
  logic rsp_vld;
  logic rsp_dat;
  logic owr_oe;
  logic owr_i;
  logic slave_low = 1'b0;

  assign owr_i = ~(owr_oe | slave_low);

  onewire_host #(.TSC(320)) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd_vld (cmd_vld),
    .cmd_rdy (cmd_rdy),
    .cmd_rst (cmd_rst),
    .cmd_dat (cmd_dat),
    .cmd_ovd (cmd_ovd),
    .rsp_vld (rsp_vld),
    .rsp_dat (rsp_dat),
    .owr_oe  (owr_oe),
    .owr_i   (owr_i)
  );

  always #5 clk = ~clk;

`ifdef ONEWIRE_HOST_OVD_EN
  localparam int OVD_OE1 = 10;
  localparam int OVD_OE0 = 60;
  localparam int OVD_LAT = 80;
`else
  localparam int OVD_OE1 = 80;
  localparam int OVD_OE0 = 480;
  localparam int OVD_LAT = 640;
`endif

  typedef struct {
    logic dat;
    int   at;
    int   oe;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   acc = 0;
  int   mode = 0;
  int   oe_cnt = 0;
  int   last_rsp = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Slave windows, in clocks after acceptance:
  // 1 = read-low, 2 = presence, 3 = whole slot low.
  always @(negedge clk) begin
    int rel;
    rel = cyc - acc;
    case (mode)
      1:       slave_low = (rel >= 0) && (rel < 320);
      2:       slave_low = (rel >= 3520) && (rel < 4800);
      3:       slave_low = (rel >= 0) && (rel < 640);
      default: slave_low = 1'b0;
    endcase
  end

  // Monitor: one line per completed transaction
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      oe_cnt = 0;
    end else begin
      if (owr_oe) oe_cnt++;
      if (rsp_vld) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=rsp_vld expected=none at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          $display("rsp cycle=%0d dat=%0d oe_clocks=%0d (exp cycle=%0d dat=%0d oe=%0d)",
                   cyc, rsp_dat, oe_cnt, e.at, e.dat, e.oe);
          chk("rsp_dat", int'(rsp_dat), int'(e.dat));
          chk("rsp_time", cyc, e.at);
          chk("oe_clocks", oe_cnt, e.oe);
        end
        oe_cnt   = 0;
        last_rsp = cyc;
      end
    end
  end

  task automatic do_cmd(input logic r, input logic d, input logic o, input int m,
                        input logic ed, input int lat, input int oe,
                        input bit push, input bit b2b);
    int n;
    n = 0;
    @(negedge clk);
    cmd_rst = r;
    cmd_dat = d;
    cmd_ovd = o;
    while (!cmd_rdy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_rdy) begin
      chk("cmd_rdy_timeout", 0, 1);
      return;
    end
    cmd_vld = 1'b1;
    @(posedge clk);
    #1;
    acc  = cyc;
    mode = m;
    cmd_vld = 1'b0;
    // Scramble the command inputs after acceptance. They must have no effect.
    cmd_dat = ~d;
    cmd_rst = ~r;
    cmd_ovd = ~o;
    if (push) sb.push_back('{ed, acc + lat, oe});
    if (b2b) chk("b2b_gap", acc - last_rsp, 2);
  endtask

  initial begin
    int n;
    #12;
    chk("rst_cmd_rdy", int'(cmd_rdy), 0);
    chk("rst_owr_oe", int'(owr_oe), 0);
    chk("rst_rsp_vld", int'(rsp_vld), 0);
    chk("rst_rsp_dat", int'(rsp_dat), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", int'(cmd_rdy), 1);

    //     rst  dat  ovd  mode dat  lat      oe       push b2b
    do_cmd(1'b0, 1'b1, 1'b0, 0, 1'b1, 640,     80,      1, 0); // write-1
    do_cmd(1'b0, 1'b0, 1'b0, 0, 1'b0, 640,     480,     1, 1); // write-0
    do_cmd(1'b0, 1'b1, 1'b0, 1, 1'b0, 640,     80,      1, 1); // read, slave low
    do_cmd(1'b0, 1'b1, 1'b0, 0, 1'b1, 640,     80,      1, 1); // read, silent
    do_cmd(1'b1, 1'b0, 1'b0, 2, 1'b1, 5120,    3200,    1, 1); // reset, presence
    do_cmd(1'b1, 1'b0, 1'b0, 0, 1'b0, 5120,    3200,    1, 1); // reset, no slave
    do_cmd(1'b0, 1'b1, 1'b1, 0, 1'b1, OVD_LAT, OVD_OE1, 1, 1); // overdrive write-1
    do_cmd(1'b0, 1'b0, 1'b1, 0, 1'b0, OVD_LAT, OVD_OE0, 1, 1); // overdrive write-0
    do_cmd(1'b0, 1'b1, 1'b0, 3, 1'b0, 640,     80,      1, 1); // wire held low
    do_cmd(1'b0, 1'b1, 1'b0, 0, 1'b1, 640,     80,      1, 1); // write-1

    // Abort a reset cycle at clock 1000.
    do_cmd(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 1);
    while (cyc < acc + 1000) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_owr_oe", int'(owr_oe), 0);
    chk("abort_cmd_rdy", int'(cmd_rdy), 0);
    chk("abort_rsp_dat", int'(rsp_dat), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_rdy_release", int'(cmd_rdy), 1);
    $display("abort cycle=%0d rdy=%0d", cyc, cmd_rdy);

    do_cmd(1'b0, 1'b1, 1'b0, 0, 1'b1, 640, 80, 1, 0);       // write-1 after abort

    n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb.size(), 0);
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onewire_host.md
ONEWIRE_HOST -- requirements
Module: onewire_host

Interface
REQ-001 SHALL have parameter TSC, default 320, meaning clock cycles per normal-speed time slot S; TSC SHALL be a multiple of 32.
REQ-002 SHALL have clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have cmd_vld  input  1  command valid.
REQ-005 SHALL have cmd_rdy  output  1  command ready.
REQ-006 SHALL have cmd_rst  input  1  1 = reset/presence cycle, 0 = bit cycle.
REQ-007 SHALL have cmd_dat  input  1  bit to write; 1 also means read slot.
REQ-008 SHALL have cmd_ovd  input  1  overdrive select for this cycle.
REQ-009 SHALL have rsp_vld  output  1  single-cycle response strobe.
REQ-010 SHALL have rsp_dat  output  1  sampled bit (bit cycle) or presence detected (reset cycle).
REQ-011 SHALL have owr_oe  output  1  1 = drive wire low (open-drain enable).
REQ-012 SHALL have owr_i  input  1  wire level, asynchronous.

Function
REQ-013 SHALL pass owr_i through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-014 SHALL derive quarter-slot tick period Q = TSC/4 clocks normal, TSC/32 clocks overdrive, via a prescaler restarted at command acceptance.
REQ-015 SHALL implement states IDLE, BIT, RST; cmd_rdy = 1 only in IDLE.
REQ-016 SHALL accept a command when cmd_vld & cmd_rdy, latching cmd_rst, cmd_dat and cmd_ovd; IDLE -> RST if cmd_rst, else IDLE -> BIT.
REQ-017 SHALL assert owr_oe the clock after acceptance; owr_oe SHALL be 0 in IDLE.
REQ-018 BIT: owr_oe high for quarters 0..0 (1 Q) if cmd_dat=1, quarters 0..5 (6 Q) if cmd_dat=0; sample wire at end of quarter 1 (2 Q); cycle length 8 Q.
REQ-019 RST: owr_oe high for quarters 0..39 (40 Q = 10 S); sample wire at end of quarter 49 (50 Q); cycle length 64 Q.
REQ-020 rsp_dat SHALL be the sampled level in BIT and its inverse (presence) in RST, held until next response.
REQ-021 On the final clock of a cycle SHALL pulse rsp_vld for one clock and return to IDLE; cmd_rdy rises the next clock, so back-to-back cycles are separated by exactly one idle clock.
REQ-022 cmd_* inputs SHALL be ignored outside acceptance; changes mid-cycle have no effect.
REQ-023 A wire held low externally SHALL NOT stall the state machine; timing is purely counter-driven.

Reset
REQ-024 rst SHALL asynchronously force state IDLE, owr_oe=0, rsp_vld=0, rsp_dat=0, counters and synchronizer to 0; cmd_rdy=0 while rst high.
REQ-025 rst mid-cycle SHALL abort the cycle with no rsp_vld; cmd_rdy=1 the first clock after rst deasserts.

Configuration
REQ-026 Macro ONEWIRE_HOST_OVD_EN defined: cmd_ovd selects overdrive timing per REQ-014.
REQ-027 Macro ONEWIRE_HOST_OVD_EN undefined: cmd_ovd SHALL be ignored and all cycles use normal timing; port list unchanged.

Verification (TSC=320, Q=80 normal / 10 overdrive)
REQ-028 Write-1, line otherwise idle high -> owr_oe high 80 clocks, rsp_vld at clock 640 after acceptance, rsp_dat=1.
REQ-029 Write-0 -> owr_oe high 480 clocks, rsp_dat=0, rsp_vld at 640.
REQ-030 Read slot with slave holding wire low clocks 0..320 -> rsp_dat=0; slave silent -> rsp_dat=1.
REQ-031 Reset cycle, slave presence low clocks 3520..4800 -> owr_oe high 3200 clocks, rsp_vld at 5120, rsp_dat=1; no slave -> rsp_dat=0.
REQ-032 Overdrive write-1 with ONEWIRE_HOST_OVD_EN -> owr_oe 10 clocks, rsp_vld at 80; without macro -> 80 and 640.
REQ-033 rst pulsed at clock 1000 of a reset cycle -> owr_oe drops immediately, no rsp_vld, cmd_rdy=1 one clock after rst release.
